processor_stage1: RTL and testbench
===================================

# processor_stage1

Instruction fetch stage of the asm18 pipeline. It owns the instruction pointer, drives a synchronous code memory, and hands `no_operation`, `ip` and `code_word` to the register/memory read stage (stage 2). It handles four control events:
- jump redirects from downstream,
- stall/bubble insertion for hazards,
- the one-cycle restart bubble after reset,
- the `OP_WAIT` sleep state, which is left on a `wake` pulse.

## Interface
- `ADDR_SIZE`, 18, width of instruction addresses.
- `WORD_SIZE`, 18, width of instruction words.
- `RESET_ADDR`, 0, first instruction address after reset.

- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `code_addr`  out  ADDR_SIZE  code memory read address (combinational).
- `code_word_in`  in  WORD_SIZE  code memory data, valid one cycle after `code_addr`.
- `jump_enable`  in  1  redirect request from a downstream stage.
- `jump_addr`  in  ADDR_SIZE  redirect target.
- `stall`  in  1  hold current instruction and send a bubble downstream.
- `wake`  in  1  leave the WAIT state.
- `no_operation`  out  1  high = stage 2 must treat `code_word` as a bubble.
- `ip`  out  ADDR_SIZE  address of the word on `code_word`.
- `code_word`  out  WORD_SIZE  equals `code_word_in`.
- `waiting`  out  1  high while in the WAIT state.

## Operation
- **Registers**
  - `fetch_ip`: address of the word currently returning from memory.
  - `state`: one of PRIME, RUN, WAIT.
- **Outputs**
  - `ip` = `fetch_ip`.
  - `code_word` = `code_word_in`.
  - `no_operation` = reset | (state≠RUN) | `jump_enable` | `stall`.
  - `waiting` = (state==WAIT).
- **Next-state priority:** reset > jump > (WAIT: wake) > stall > PRIME > RUN advance.
  - **reset:** `code_addr`=`RESET_ADDR`; `fetch_ip`←`RESET_ADDR`; state←PRIME.
  - **jump_enable** (any state): `code_addr`=`jump_addr`; `fetch_ip`←`jump_addr`; state←RUN. The word presented this cycle is squashed.
  - **WAIT**
    - `code_addr`=`fetch_ip`+1.
    - On `wake`: `fetch_ip`←`fetch_ip`+1, state←RUN.
    - Otherwise the state holds.
    - `stall` is ignored in WAIT.
  - **stall** (PRIME/RUN): `code_addr`=`fetch_ip`; no register change.
  - **PRIME:** `code_addr`=`fetch_ip`; state←RUN.
  - **RUN**
    - If `code_word_in[17:14]`==`OP_WAIT`: the instruction passes to stage 2 (`no_operation`=0); `code_addr`=`fetch_ip`+1; `fetch_ip` is unchanged; state←WAIT.
    - Otherwise: `code_addr`=`fetch_ip`+1; `fetch_ip`←`fetch_ip`+1.
- **Arithmetic:** `fetch_ip`+1 is modulo 2^ADDR_SIZE; `fetch_ip`=2^18−1 wraps to 0.
- **Wake timing:** `wake` is sampled only in WAIT. A pulse that arrives before the WAIT state is entered is lost; software must not depend on early wakes.
- **Stall during OP_WAIT:** an `OP_WAIT` under `stall` is not consumed. WAIT is entered only on the cycle it actually passes.

## Timing
- Code memory read latency is 1 cycle. `code_addr` is combinational from the registers and the inputs.
- First valid instruction appears 2 cycles after reset deasserts: one PRIME bubble, then RUN.
- **Jump penalty:** the cycle with `jump_enable` is a bubble; the target word is presented on the next cycle with `no_operation`=0 unless stalled.
- **Wake:** zero-bubble resume. The word at `fetch_ip`+1 is presented the cycle after `wake`.
- **Reset values**
  - During reset: `no_operation`=1, `code_addr`=`RESET_ADDR`.
  - After the reset edge: `ip`=`RESET_ADDR`, `waiting`=0.
- **Mid-operation reset:** reset in any state, including WAIT or a pending jump, returns to PRIME at `RESET_ADDR`.
- **Steady state:** one instruction per cycle in RUN with no stall.

## Structure
- Shared package `processor_pkg`:
  - opcode constants (`OP_*`, 4-bit, including `OP_WAIT`), shared with stage 2;
  - `fetch_state_t` enum {PRIME, RUN, WAIT}.
- Single module with no sub-module. The next-address mux and the FSM sit in one combinational block plus one clocked block.

## Test plan
- **Reset and run:** reset 2 cycles, ROM holds non-WAIT words at 0..4 → `no_operation`=1 for 1 cycle, then `ip`=0,1,2,3 on consecutive cycles with the matching words.
- **Jump:** `jump_enable`=1, `jump_addr`=0x100 while `ip`=3 → that cycle `no_operation`=1; next cycle `ip`=0x100, `no_operation`=0; then 0x101.
- **Stall:** `stall` high 3 cycles at `ip`=5 → `no_operation`=1 and `ip`=5 for 3 cycles; then `ip`=5 with `no_operation`=0, then 6.
- **WAIT:**
  - `OP_WAIT` at address 7 → presented once with `no_operation`=0, then `waiting`=1 and bubbles.
  - `wake` after 10 cycles → next cycle `ip`=8, `waiting`=0.
  - A `wake` pulse on the cycle the `OP_WAIT` word is presented (state RUN) → ignored; the block stays in WAIT.
- **Wrap and priority:** `jump_addr`=0x3FFFF → next `ip`=0x3FFFF, then 0. `jump_enable` together with `wake` in WAIT → jump target wins.
- **Reset in WAIT:** reset asserted in WAIT → `waiting`=0; restart at `RESET_ADDR` after one PRIME bubble.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared definitions for the asm18 pipeline: opcode encodings and fetch-stage states.
package processor_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_ADD    = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_SUB    = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_AND    = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_OR     = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_XOR    = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_SHIFT  = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_LOADI  = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_JUMP   = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_CALL   = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_RET    = 4'hD;
  localparam logic [OPCODE_W-1:0] OP_IO     = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_WAIT   = 4'hF;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1,
    WAIT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/processor_stage1.sv
// asm18 instruction fetch: owns the instruction pointer, addresses the synchronous
// code memory and presents ip/code_word/no_operation to the register-read stage.
module processor_stage1
  import processor_pkg::*;
#(
  parameter int                    ADDR_SIZE  = 18,
  parameter int                    WORD_SIZE  = 18,
  parameter logic [ADDR_SIZE-1:0]  RESET_ADDR = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [ADDR_SIZE-1:0] code_addr,
  input  logic [WORD_SIZE-1:0] code_word_in,
  input  logic                 jump_enable,
  input  logic [ADDR_SIZE-1:0] jump_addr,
  input  logic                 stall,
  input  logic                 wake,
  output logic                 no_operation,
  output logic [ADDR_SIZE-1:0] ip,
  output logic [WORD_SIZE-1:0] code_word,
  output logic                 waiting
);

  fetch_state_t         state_q, state_d;
  logic [ADDR_SIZE-1:0] fetch_ip_q, fetch_ip_d;
  logic [ADDR_SIZE-1:0] ip_inc;
  logic [OPCODE_W-1:0]  opcode;

  assign ip_inc = fetch_ip_q + 1'b1;
  assign opcode = code_word_in[WORD_SIZE-1 -: OPCODE_W];

  always_comb begin
    state_d    = state_q;
    fetch_ip_d = fetch_ip_q;
    code_addr  = ip_inc;

    if (reset) begin
      code_addr  = RESET_ADDR;
      fetch_ip_d = RESET_ADDR;
      state_d    = PRIME;
    end else if (jump_enable) begin
      code_addr  = jump_addr;
      fetch_ip_d = jump_addr;
      state_d    = RUN;
    end else if (state_q == WAIT) begin
      // Keep the following word in flight so a wake resumes without a bubble.
      code_addr = ip_inc;
      if (wake) begin
        fetch_ip_d = ip_inc;
        state_d    = RUN;
      end
    end else if (stall) begin
      code_addr = fetch_ip_q;
    end else if (state_q == PRIME) begin
      code_addr = fetch_ip_q;
      state_d   = RUN;
    end else if (opcode == OP_WAIT) begin
      code_addr = ip_inc;
      state_d   = WAIT;
    end else begin
      code_addr  = ip_inc;
      fetch_ip_d = ip_inc;
    end
  end

  always_ff @(posedge clock) begin
    state_q    <= state_d;
    fetch_ip_q <= fetch_ip_d;
  end

  assign ip           = fetch_ip_q;
  assign code_word    = code_word_in;
  assign no_operation = reset | (state_q != RUN) | jump_enable | stall;
  assign waiting      = (state_q == WAIT);

endmodule

// File: tb/tb_processor_stage1.sv
// Bench for processor_stage1: directed pipeline scenarios plus random control traffic,
// checked every cycle against an instruction-stream model of the fetch stage.
module tb_processor_stage1;
  import processor_pkg::*;

  localparam int AW = 18;
  localparam int WW = 18;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] code_addr;
  logic [WW-1:0] code_word_in;
  logic          jump_enable;
  logic [AW-1:0] jump_addr;
  logic          stall;
  logic          wake;
  logic          no_operation;
  logic [AW-1:0] ip;
  logic [WW-1:0] code_word;
  logic          waiting;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  processor_stage1 #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .RESET_ADDR('0)) dut (
    .clock        (clock),
    .reset        (reset),
    .code_addr    (code_addr),
    .code_word_in (code_word_in),
    .jump_enable  (jump_enable),
    .jump_addr    (jump_addr),
    .stall        (stall),
    .wake         (wake),
    .no_operation (no_operation),
    .ip           (ip),
    .code_word    (code_word),
    .waiting      (waiting)
  );

  // Code ROM contents: OP_WAIT at every address whose low nibble is 7.
  function automatic logic [WW-1:0] rom(input logic [AW-1:0] a);
    logic [3:0] op;
    int         v;
    v = int'(a);
    if (a[3:0] == 4'd7) op = OP_WAIT;
    else                op = 4'((v * 5 + 3) % 15);
    return {op, a[13:0] ^ 14'h2A5A};
  endfunction

  always @(posedge clock) code_word_in <= rom(code_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction-stream model: m_ip is the address being presented, m_prime marks the
  // restart bubble, m_sleep marks the WAIT sleep.
  logic          armed = 1'b0;
  logic          m_prime, m_sleep, exp_nop;
  logic [AW-1:0] m_ip, exp_addr;
  logic [WW-1:0] m_word;

  always @(negedge clock) begin
    m_word = rom(m_ip);
    if (armed) begin
      exp_nop = reset || m_prime || m_sleep || jump_enable || stall;
      if (reset)                          exp_addr = '0;
      else if (jump_enable)               exp_addr = jump_addr;
      else if (m_sleep)                   exp_addr = m_ip + 1'b1;
      else if (stall || m_prime)          exp_addr = m_ip;
      else                                exp_addr = m_ip + 1'b1;
      chk("model.no_operation", no_operation, exp_nop);
      chk("model.ip", ip, m_ip);
      chk("model.waiting", waiting, m_sleep);
      chk("model.code_addr", code_addr, exp_addr);
      if (!exp_nop) chk("model.code_word", code_word, m_word);
    end
    if (reset) begin
      m_ip = '0; m_prime = 1'b1; m_sleep = 1'b0; armed = 1'b1;
    end else if (jump_enable) begin
      m_ip = jump_addr; m_prime = 1'b0; m_sleep = 1'b0;
    end else if (m_sleep) begin
      if (wake) begin
        m_ip = m_ip + 1'b1; m_sleep = 1'b0;
      end
    end else if (!stall) begin
      if (m_prime)                         m_prime = 1'b0;
      else if (m_word[17:14] == OP_WAIT)   m_sleep = 1'b1;
      else                                 m_ip = m_ip + 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic lit(input string nm, input logic en, input logic [AW-1:0] eip,
                     input logic ew);
    #1;
    chk({nm, ".no_operation"}, no_operation, en);
    chk({nm, ".ip"}, ip, eip);
    chk({nm, ".waiting"}, waiting, ew);
    if (!en) chk({nm, ".code_word"}, code_word, rom(eip));
  endtask

  initial begin
    reset = 1'b1; jump_enable = 1'b0; jump_addr = '0; stall = 1'b0; wake = 1'b0;

    // Reset and run
    cyc(); cyc();
    #1;
    chk("reset.code_addr", code_addr, 0);
    chk("reset.no_operation", no_operation, 1);
    chk("reset.ip", ip, 0);
    chk("reset.waiting", waiting, 0);
    cyc(); reset = 1'b0; lit("prime", 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); lit("run", 0, AW'(i), 0);
    end
    // Jump
    cyc(); jump_enable = 1'b1; jump_addr = 18'h100; lit("jump_req", 1, 3, 0);
    cyc(); jump_enable = 1'b0; lit("jump_tgt", 0, 18'h100, 0);
    cyc(); lit("jump_next", 0, 18'h101, 0);

    // Stall and WAIT
    cyc(); reset = 1'b1; lit("reset_run", 1, 18'h102, 0);
    cyc(); reset = 1'b0; lit("prime2", 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(); lit("run2", 0, AW'(i), 0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); stall = 1'b1; lit("stall", 1, 5, 0);
    end
    cyc(); stall = 1'b0; lit("stall_release", 0, 5, 0);
    cyc(); lit("after_stall", 0, 6, 0);
    cyc(); wake = 1'b1; lit("op_wait_early_wake", 0, 7, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(); wake = 1'b0; lit("sleeping", 1, 7, 1);
    end
    cyc(); wake = 1'b1; lit("wake_cycle", 1, 7, 1);
    cyc(); wake = 1'b0; lit("woken", 0, 8, 0);

    // Wrap and jump-over-wake priority
    cyc(); jump_enable = 1'b1; jump_addr = 18'h3FFFF; lit("wrap_req", 1, 9, 0);
    cyc(); jump_enable = 1'b0; lit("wrap_top", 0, 18'h3FFFF, 0);
    cyc(); lit("wrap_zero", 0, 0, 0);
    cyc(); jump_enable = 1'b1; jump_addr = 18'h7; lit("jump_to_wait", 1, 1, 0);
    cyc(); jump_enable = 1'b0; lit("wait_word", 0, 7, 0);
    cyc(); jump_enable = 1'b1; jump_addr = 18'h200; wake = 1'b1;
    lit("jump_wake_req", 1, 7, 1);
    cyc(); jump_enable = 1'b0; wake = 1'b0; lit("jump_beats_wake", 0, 18'h200, 0);

    // Reset while sleeping
    cyc(); jump_enable = 1'b1; jump_addr = 18'h17; lit("jump_to_wait2", 1, 18'h201, 0);
    cyc(); jump_enable = 1'b0; lit("wait_word2", 0, 18'h17, 0);
    cyc(); reset = 1'b1; lit("reset_in_wait", 1, 18'h17, 1);
    cyc(); reset = 1'b0; lit("prime3", 1, 0, 0);
    cyc(); lit("restart", 0, 0, 0);

    // Random control traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset       = ($urandom % 150) == 0;
      jump_enable = ($urandom % 20) == 0;
      if ($urandom_range(0, 3) == 0) jump_addr = 18'h3FFF0 | AW'($urandom % 16);
      else                           jump_addr = AW'($urandom);
      stall       = ($urandom % 5) == 0;
      wake        = ($urandom % 6) == 0;
    end
    cyc();
    reset = 1'b0; jump_enable = 1'b0; stall = 1'b0; wake = 1'b0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
